// File: rtl/uart_mmio_responder_if.sv
// Data-memory style bus between the core's load/store port and the UART peripheral.
interface uart_mmio_responder_if;
    logic        chipSelect;
    logic [31:0] readAddress;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [1:0]  DQM;
    logic [31:0] readData;

    modport master (output chipSelect, readAddress, writeEnable, writeData, DQM, input readData);
    modport slave  (input chipSelect, readAddress, writeEnable, writeData, DQM, output readData);
endinterface

// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART transmitter: store-fed TX FIFO, programmable baud divider,
// combinational status/config readback.
module uart_mmio_responder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_mmio_responder_if.slave        bus,
    output logic                        txd,
    output logic                        txEmptyIrq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   baud_div, div_latched, div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic          wr, push_req, push, pop, full, empty, bit_end;
    logic [1:0]    reg_sel;
    logic [31:0]   cnt_ext;
    logic          unused_bits;

    assign reg_sel  = bus.readAddress[3:2];
    assign wr       = bus.chipSelect & bus.writeEnable;
    assign push_req = wr & (reg_sel == 2'd0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign bit_end  = (div_cnt == div_latched);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req & (~full | pop);
    assign cnt_ext  = 32'(count);

    assign txEmptyIrq  = empty & (state == IDLE);
    assign unused_bits = ^{bus.DQM, bus.readAddress[31:4], bus.readAddress[1:0],
                           bus.writeData[31:16], cnt_ext[31:4]};

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        txd       = 1'b1;
        case (state)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = START;
            end
            START: begin
                txd = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                txd = shift[0];
                if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
            end
            STOP: if (bit_end) begin
                // Chain straight into the next frame when data is waiting.
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            baud_div    <= 16'(DEFAULT_DIV);
            div_latched <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= 8'hFF;
        end else begin
            state <= state_nxt;
            if (push) begin
                mem[wr_ptr] <= bus.writeData[7:0];
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (push_req && full && !pop)                         overflow <= 1'b1;
            else if (wr && reg_sel == 2'd1 && bus.writeData[3])   overflow <= 1'b0;
            if (wr && reg_sel == 2'd2) baud_div <= bus.writeData[15:0];
            if (pop) begin
                shift       <= mem[rd_ptr];
                div_latched <= baud_div;
                div_cnt     <= '0;
                bit_cnt     <= '0;
            end else if (state != IDLE) begin
                if (bit_end) begin
                    div_cnt <= '0;
                    if (state == DATA) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        bus.readData = '0;
        if (bus.chipSelect) begin
            case (reg_sel)
                2'd1:    bus.readData = {24'd0, cnt_ext[3:0], overflow, state != IDLE, empty, full};
                2'd2:    bus.readData = {16'd0, baud_div};
                default: bus.readData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder: frame-level reference model compared every cycle,
// plus hand-computed expectations at the interesting edges.
module tb_uart_mmio_responder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd, txEmptyIrq;
    int   checks = 0;
    int   errors = 0;
    bit   live   = 1'b0;

    uart_mmio_responder_if bus();

    uart_mmio_responder #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(15)) dut (
        .clk(clk), .rst(rst), .bus(bus), .txd(txd), .txEmptyIrq(txEmptyIrq));

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: a byte queue plus the position inside the current 10-bit frame.
    logic [7:0] mq[$];
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_popped;
    int         m_baud = 15;
    int         m_div  = 0;
    int         m_pos  = -1;
    bit         m_ovf  = 1'b0;
    bit         m_wr, m_pop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_baud = 15;
            m_ovf  = 1'b0;
            m_pos  = -1;
        end else begin
            m_wr  = (bus.chipSelect === 1'b1) && (bus.writeEnable === 1'b1);
            m_pop = (mq.size() != 0) && (m_pos == -1 || m_pos == 10 * (m_div + 1) - 1);
            if (m_pop) m_popped = mq.pop_front();
            if (m_wr && bus.readAddress[3:2] == 2'd0) begin
                if (mq.size() < DEPTH) mq.push_back(bus.writeData[7:0]);
                else m_ovf = 1'b1;
            end
            if (m_wr && bus.readAddress[3:2] == 2'd1 && bus.writeData[3]) m_ovf = 1'b0;
            if (m_pop) begin
                m_byte = m_popped;
                m_div  = m_baud;
                m_pos  = 0;
            end else if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == 10 * (m_div + 1)) m_pos = -1;
            end
            if (m_wr && bus.readAddress[3:2] == 2'd2) m_baud = int'(bus.writeData[15:0]);
        end
    end

    function automatic logic m_txd();
        logic [9:0] frame;
        if (m_pos < 0) return 1'b1;
        frame = {1'b1, m_byte, 1'b0};
        return frame[m_pos / (m_div + 1)];
    endfunction

    function automatic logic [31:0] m_rdata();
        logic [31:0] st;
        if (bus.chipSelect !== 1'b1) return 32'd0;
        st = {24'd0, 4'(mq.size()), m_ovf, m_pos >= 0, mq.size() == 0, mq.size() == DEPTH};
        case (bus.readAddress[3:2])
            2'd1:    return st;
            2'd2:    return 32'(m_baud);
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (live) begin
            chk("model_txd", 32'(txd), 32'(m_txd()));
            chk("model_irq", 32'(txEmptyIrq), 32'((mq.size() == 0) && (m_pos < 0)));
            chk("model_rdata", bus.readData, m_rdata());
        end
    end

    task automatic drive(logic cs, logic we, logic [31:0] addr, logic [31:0] data);
        bus.chipSelect  = cs;
        bus.writeEnable = we;
        bus.readAddress = addr;
        bus.writeData   = data;
        bus.DQM         = 2'b10;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] addr, logic [31:0] data);
        drive(1'b1, 1'b1, addr, data);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h4, 32'h0);
    endtask

    task automatic rd_chk(string name, logic [31:0] addr, logic [31:0] exp);
        drive(1'b1, 1'b0, addr, 32'h0);
        @(negedge clk);
        chk(name, bus.readData, exp);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h4, 32'h0);
    endtask

    task automatic st_chk(string name, logic [31:0] exp);
        @(negedge clk);
        chk(name, bus.readData, exp);
    endtask

    task automatic wait_idle(string name, int max, output int n);
        n = 0;
        idle(1);
        while (txEmptyIrq !== 1'b1 && n < max) begin
            idle(1);
            n++;
        end
        chk(name, 32'(txEmptyIrq), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] frame;
        int         n;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        idle(2);
        rst  = 1'b0;
        live = 1'b1;

        // Reset state
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_irq", 32'(txEmptyIrq), 32'd1);
        rd_chk("reset_status", 32'h4, 32'h2);
        rd_chk("reset_baud", 32'h8, 32'd15);
        rd_chk("txdata_reads_0", 32'h0, 32'h0);
        rd_chk("reserved_reads_0", 32'hC, 32'h0);

        // Single byte 0xA5 at divider 3: start low E+1..E+4, 4 clocks per bit
        wr(32'h8, 32'd3);
        wr(32'h0, 32'hA5);
        frame = 10'b1101001010;
        for (int j = 0; j <= 41; j++) begin
            @(negedge clk);
            chk("a5_txd", 32'(txd), (j == 0 || j >= 41) ? 32'd1 : 32'(frame[(j - 1) / 4]));
            if (j == 40) chk("a5_busy_e40", bus.readData, 32'h6);
            if (j == 41) begin
                chk("a5_idle_e41", bus.readData, 32'h2);
                chk("a5_irq_e41", 32'(txEmptyIrq), 32'd1);
            end
        end
        idle(1);

        // Back-to-back frames at divider 0
        wr(32'h8, 32'd0);
        wr(32'h0, 32'h55);
        wr(32'h0, 32'h0F);
        st_chk("b2b_count1", 32'h14);
        for (int j = 2; j <= 11; j++) begin
            @(negedge clk);
            if (j == 10) chk("b2b_stop_e10", 32'(txd), 32'd1);
            if (j == 11) begin
                chk("b2b_start_e11", 32'(txd), 32'd0);
                chk("b2b_count0_e11", bus.readData, 32'h6);
            end
        end
        wait_idle("b2b_idle", 100, n);

        // Overflow: sixth push while four are queued and a frame is running
        wr(32'h8, 32'd3);
        for (int b = 1; b <= 6; b++) wr(32'h0, 32'(b * 8'h11));
        st_chk("ovf_status", 32'h4D);
        idle(1);
        wr(32'h4, 32'h8);
        st_chk("ovf_cleared", 32'h45);
        wait_idle("ovf_idle", 400, n);
        chk("ovf_five_frames_cycles", 32'(n), 32'd193);

        // Push lands on the STOP-end pop edge while full
        for (int b = 0; b < 5; b++) wr(32'h0, 32'(8'hC0 + b));
        st_chk("pp_full", 32'h45);
        idle(36);
        wr(32'h0, 32'h99);
        st_chk("pp_same_edge", 32'h45);
        wait_idle("pp_idle", 400, n);

        // Reset during data bit 3 of a 0x00 frame
        wr(32'h0, 32'h00);
        wr(32'h0, 32'h00);
        idle(17);
        chk("mid_data_txd_low", 32'(txd), 32'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_irq", 32'(txEmptyIrq), 32'd1);
        rd_chk("rst_mid_status", 32'h4, 32'h2);
        rd_chk("rst_mid_baud", 32'h8, 32'd15);

        // chipSelect low: no side effects, readData 0
        drive(1'b0, 1'b1, 32'h0, 32'h77);
        @(negedge clk);
        chk("cs0_rdata", bus.readData, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h8, 32'h1);
        idle(1);
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        idle(3);
        chk("cs0_txd_idle", 32'(txd), 32'd1);
        rd_chk("cs0_status", 32'h4, 32'h2);
        rd_chk("cs0_baud", 32'h8, 32'd15);

        live = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
